// File: rtl/alu_muldiv.sv
// Iterative integer multiply/divide unit (MULU, MUL, DIVU, DIV) with selectable operand width.
// Latency: done on the (N/STEP+2)th ce edge after start; divide-by-zero and DIVU overflow finish on the 2nd.
// Backpressure: none; ce=0 freezes all state, and a start seen while busy is dropped.
module alu_muldiv #(
    parameter int W    = 16,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           wide,
    input  logic [2*W-1:0] ta,
    input  logic [W-1:0]   tb,
    output logic [W-1:0]   result_lo,
    output logic [W-1:0]   result_hi,
    output logic           cy,
    output logic           v,
    output logic           busy,
    output logic           done,
    output logic           div_err
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W / STEP + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;
    state_t state;

    logic [1:0]     op_q;
    logic           wide_q;
    logic [2*W-1:0] ta_q;
    logic [W-1:0]   tb_q;
    logic [2*W-1:0] prod, mc;
    logic [W-1:0]   mp, rem, quo, dvs;
    logic           neg_q, neg_r, err_q;
    logic [CW-1:0]  cnt;

    // operand preparation and sign-correction logic
    logic           sgn, a_s, b_s, d_s, hi_ovf, div_early, lo_msb, mul_ovf, q_err, fix_err;
    logic [W-1:0]   mask_n, a_n, b_n, a_mag, b_mag, d_hi, d_lo, lim;
    logic [W-1:0]   mul_lo, mul_hi, q_fix, r_fix;
    logic [2*W-1:0] mask_2n, d2, d_mag, p_fix;
    logic [CW-1:0]  iter_cnt;

    always_comb begin
        mask_n   = wide_q ? {W{1'b1}} : {{(W-H){1'b0}}, {H{1'b1}}};
        mask_2n  = wide_q ? {(2*W){1'b1}} : {{W{1'b0}}, {W{1'b1}}};
        iter_cnt = wide_q ? CW'(W / STEP) : CW'(H / STEP);
        sgn      = op_q[0];

        a_n   = ta_q[W-1:0] & mask_n;
        b_n   = tb_q & mask_n;
        a_s   = sgn & (wide_q ? ta_q[W-1] : ta_q[H-1]);
        b_s   = sgn & (wide_q ? tb_q[W-1] : tb_q[H-1]);
        a_mag = a_s ? ((-a_n) & mask_n) : a_n;
        b_mag = b_s ? ((-b_n) & mask_n) : b_n;

        d2    = ta_q & mask_2n;
        d_s   = sgn & (wide_q ? ta_q[2*W-1] : ta_q[W-1]);
        d_mag = d_s ? ((-d2) & mask_2n) : d2;
        d_hi  = wide_q ? d_mag[2*W-1:W] : {{(W-H){1'b0}}, d_mag[W-1:H]};
        d_lo  = wide_q ? d_mag[W-1:0]   : {{(W-H){1'b0}}, d_mag[H-1:0]};
        // A high half >= divisor means the quotient cannot fit in N bits.
        hi_ovf    = (d_hi >= b_mag);
        div_early = (b_n == '0) || (!sgn && hi_ovf);

        p_fix   = neg_q ? ((-prod) & mask_2n) : prod;
        mul_lo  = wide_q ? p_fix[W-1:0]   : {{(W-H){1'b0}}, p_fix[H-1:0]};
        mul_hi  = wide_q ? p_fix[2*W-1:W] : {{(W-H){1'b0}}, p_fix[W-1:H]};
        lo_msb  = wide_q ? mul_lo[W-1] : mul_lo[H-1];
        mul_ovf = sgn ? (mul_hi != (lo_msb ? mask_n : '0)) : (mul_hi != '0);

        q_fix   = neg_q ? ((-quo) & mask_n) : quo;
        r_fix   = neg_r ? ((-rem) & mask_n) : rem;
        lim     = wide_q ? (W'(1) << (W - 1)) : (W'(1) << (H - 1));
        q_err   = sgn && (neg_q ? (quo > lim) : (quo >= lim));
        fix_err = op_q[1] && (err_q || q_err);
    end

    // STEP bits of shift-add and restoring shift-subtract per ITER edge
    logic [2*W-1:0] prod_nx, mc_nx;
    logic [W-1:0]   mp_nx, rem_nx, quo_nx;
    logic [W:0]     sh;

    always_comb begin
        prod_nx = prod;
        mc_nx   = mc;
        mp_nx   = mp;
        rem_nx  = rem;
        quo_nx  = quo;
        sh      = '0;
        for (int s = 0; s < STEP; s++) begin
            if (mp_nx[0])
                prod_nx = prod_nx + mc_nx;
            mc_nx  = mc_nx << 1;
            mp_nx  = mp_nx >> 1;
            sh     = {rem_nx, (wide_q ? quo_nx[W-1] : quo_nx[H-1])};
            quo_nx = (quo_nx << 1) & mask_n;
            if (sh >= {1'b0, dvs}) begin
                sh        = sh - {1'b0, dvs};
                quo_nx[0] = 1'b1;
            end
            rem_nx = sh[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= '0;
            wide_q    <= 1'b0;
            ta_q      <= '0;
            tb_q      <= '0;
            prod      <= '0;
            mc        <= '0;
            mp        <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            cy        <= 1'b0;
            v         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_err   <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        wide_q  <= wide;
                        ta_q    <= ta;
                        tb_q    <= tb;
                        busy    <= 1'b1;
                        div_err <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= iter_cnt;
                    neg_r <= d_s;
                    prod  <= '0;
                    if (op_q[1]) begin
                        rem   <= d_hi;
                        quo   <= d_lo;
                        dvs   <= b_mag;
                        neg_q <= d_s ^ b_s;
                        // Early errors skip ITER so done lands on the 2nd edge.
                        err_q <= div_early || (sgn && hi_ovf);
                        state <= div_early ? FIX : ITER;
                    end else begin
                        mc    <= {{W{1'b0}}, a_mag};
                        mp    <= b_mag;
                        neg_q <= a_s ^ b_s;
                        err_q <= 1'b0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    prod <= prod_nx;
                    mc   <= mc_nx;
                    mp   <= mp_nx;
                    rem  <= rem_nx;
                    quo  <= quo_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (fix_err) begin
                        div_err <= 1'b1;
                    end else if (op_q[1]) begin
                        result_lo <= q_fix;
                        result_hi <= r_fix;
                        cy        <= 1'b0;
                        v         <= 1'b0;
                    end else begin
                        result_lo <= mul_lo;
                        result_hi <= mul_hi;
                        cy        <= mul_ovf;
                        v         <= mul_ovf;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
